// File: rtl/quad_pkg.sv
// Shared types for the quadrature position tracker: decoder states and
// step-direction constants.
package quad_pkg;

    // Low two bits of every settled state are the filtered {A,B} levels
    typedef enum logic [2:0] {
        S00  = 3'b000,
        S01  = 3'b001,
        S10  = 3'b010,
        S11  = 3'b011,
        INIT = 3'b100
    } quad_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    function automatic logic is_right_move(input logic [1:0] from_ab, input logic [1:0] to_ab);
        logic right;
        right = 1'b0;
        case ({from_ab, to_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: right = 1'b1;
            default:                            right = 1'b0;
        endcase
        return right;
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: 2-flop synchronizer followed by a FILT_LEN-sample
// agreement filter on the synchronized level.
module quad_debounce #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] agree_cnt;

    // The filtered level only moves once FILT_LEN consecutive samples disagree with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b00;
            agree_cnt <= '0;
            filt      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] != filt) begin
                if (agree_cnt == CW'(FILT_LEN - 1)) begin
                    filt      <= sync_q[1];
                    agree_cnt <= '0;
                end else begin
                    agree_cnt <= agree_cnt + 1'b1;
                end
            end else begin
                agree_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quadrature_position_tracker.sv
// Quadrature encoder decoder: debounced channels feed a Gray-code FSM that
// drives a position counter, a one-hot LED ripple and an error counter.
module quadrature_position_tracker
    import quad_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ROT_A,
    input  logic                ROT_B,
    input  logic                quad_x4,
    input  logic                sat_en,
    input  logic                pos_clr,
    output logic [NUM_LEDS-1:0] led,
    output logic [CNT_W-1:0]    position,
    output logic                rotation_event,
    output logic                rotation_direction,
    output logic                err_pulse,
    output logic [7:0]          err_cnt
);

    localparam int SETTLE = FILT_LEN + 2;
    localparam int SW     = $clog2(SETTLE + 1);

    logic        filt_a;
    logic        filt_b;
    logic [1:0]  ab;
    logic [1:0]  cur_ab;
    logic [SW-1:0] settle_cnt;
    logic        settle_done;

    quad_state_t state;
    quad_state_t state_next;
    logic        step;
    logic        step_dir;
    logic        err;

    quad_debounce #(.FILT_LEN(FILT_LEN)) u_deb_a (
        .clk  (clk),
        .rst  (rst),
        .raw  (ROT_A),
        .filt (filt_a)
    );

    quad_debounce #(.FILT_LEN(FILT_LEN)) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .raw  (ROT_B),
        .filt (filt_b)
    );

    assign ab          = {filt_a, filt_b};
    assign cur_ab      = state[1:0];
    assign settle_done = (settle_cnt == SW'(SETTLE));

    // INIT waits until the filters hold real input levels rather than their reset zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (!settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        step       = 1'b0;
        step_dir   = rotation_direction;
        err        = 1'b0;
        if (state == INIT) begin
            if (settle_done) begin
                state_next = quad_state_t'({1'b0, ab});
            end
        end else if (ab != cur_ab) begin
            state_next = quad_state_t'({1'b0, ab});
            if ((ab ^ cur_ab) == 2'b11) begin
                err = 1'b1;
            end else begin
                step_dir = is_right_move(cur_ab, ab) ? DIR_RIGHT : DIR_LEFT;
                step     = quad_x4 || (ab == 2'b11);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rotation_event     <= 1'b0;
            rotation_direction <= DIR_RIGHT;
            err_pulse          <= 1'b0;
            err_cnt            <= 8'd0;
        end else begin
            rotation_event <= step;
            err_pulse      <= err;
            if (step) begin
                rotation_direction <= step_dir;
            end
            if (err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Saturated steps still pulse rotation_event but leave position and LEDs frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position <= '0;
            led      <= NUM_LEDS'(1);
        end else if (pos_clr) begin
            position <= '0;
            led      <= NUM_LEDS'(1);
        end else if (step) begin
            if (step_dir == DIR_LEFT) begin
                if (!(sat_en && (position == {CNT_W{1'b1}}))) begin
                    position <= position + 1'b1;
                    led      <= {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
                end
            end else begin
                if (!(sat_en && (position == '0))) begin
                    position <= position - 1'b1;
                    led      <= {led[0], led[NUM_LEDS-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_quadrature_position_tracker.sv
// Directed self-checking bench for quadrature_position_tracker (default parameters).
module tb_quadrature_position_tracker;

    logic        clk;
    logic        rst;
    logic        ROT_A;
    logic        ROT_B;
    logic        quad_x4;
    logic        sat_en;
    logic        pos_clr;
    logic [7:0]  led;
    logic [15:0] position;
    logic        rotation_event;
    logic        rotation_direction;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int ev_seen;
    int err_seen;

    quadrature_position_tracker #(
        .NUM_LEDS (8),
        .CNT_W    (16),
        .FILT_LEN (4)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .ROT_A              (ROT_A),
        .ROT_B              (ROT_B),
        .quad_x4            (quad_x4),
        .sat_en             (sat_en),
        .pos_clr            (pos_clr),
        .led                (led),
        .position           (position),
        .rotation_event     (rotation_event),
        .rotation_direction (rotation_direction),
        .err_pulse          (err_pulse),
        .err_cnt            (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("[TB] check %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling 1ns after each rising edge and tallying pulses
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rotation_event === 1'b1) ev_seen++;
            if (err_pulse === 1'b1) err_seen++;
        end
    endtask

    task automatic apply_stimulus(input logic a, input logic b, input int wait_cycles);
        ROT_A = a;
        ROT_B = b;
        run_cycles(wait_cycles);
    endtask

    task automatic clear_tallies();
        ev_seen  = 0;
        err_seen = 0;
    endtask

    initial begin
        rst = 1'b1; ROT_A = 1'b1; ROT_B = 1'b1;
        quad_x4 = 1'b0; sat_en = 1'b0; pos_clr = 1'b0;
        clear_tallies();
        run_cycles(3);
        check_output("reset_position", 32'(position), 32'h0);
        check_output("reset_led", 32'(led), 32'h01);
        check_output("reset_event", 32'(rotation_event), 32'h0);
        check_output("reset_dir", 32'(rotation_direction), 32'h0);
        check_output("reset_err_cnt", 32'(err_cnt), 32'h0);

        // Idle at 11 through reset release
        rst = 1'b0;
        clear_tallies();
        run_cycles(14);
        check_output("idle_events", 32'(ev_seen), 32'h0);
        check_output("idle_errors", 32'(err_seen), 32'h0);
        check_output("idle_position", 32'(position), 32'h0);
        check_output("idle_led", 32'(led), 32'h01);

        // Three left detents, x1
        clear_tallies();
        for (int d = 0; d < 3; d++) begin
            apply_stimulus(1'b1, 1'b0, 10);
            apply_stimulus(1'b0, 1'b0, 10);
            apply_stimulus(1'b0, 1'b1, 10);
            apply_stimulus(1'b1, 1'b1, 10);
        end
        check_output("left3_events", 32'(ev_seen), 32'd3);
        check_output("left3_dir", 32'(rotation_direction), 32'h1);
        check_output("left3_position", 32'(position), 32'd3);
        check_output("left3_led", 32'(led), 32'h08);

        // Glitch on A shorter than the filter length
        clear_tallies();
        apply_stimulus(1'b0, 1'b1, 2);
        apply_stimulus(1'b1, 1'b1, 12);
        check_output("glitch_events", 32'(ev_seen), 32'h0);
        check_output("glitch_errors", 32'(err_seen), 32'h0);
        check_output("glitch_position", 32'(position), 32'd3);

        pos_clr = 1'b1;
        run_cycles(1);
        pos_clr = 1'b0;
        check_output("clr_position", 32'(position), 32'h0);
        check_output("clr_led", 32'(led), 32'h01);

        // Right detent at zero with saturation
        sat_en = 1'b1;
        clear_tallies();
        apply_stimulus(1'b0, 1'b1, 10);
        apply_stimulus(1'b0, 1'b0, 10);
        apply_stimulus(1'b1, 1'b0, 10);
        apply_stimulus(1'b1, 1'b1, 10);
        check_output("sat_events", 32'(ev_seen), 32'd1);
        check_output("sat_dir", 32'(rotation_direction), 32'h0);
        check_output("sat_position", 32'(position), 32'h0);
        check_output("sat_led", 32'(led), 32'h01);

        // Same detent wrapping
        sat_en = 1'b0;
        clear_tallies();
        apply_stimulus(1'b0, 1'b1, 10);
        apply_stimulus(1'b0, 1'b0, 10);
        apply_stimulus(1'b1, 1'b0, 10);
        apply_stimulus(1'b1, 1'b1, 10);
        check_output("wrap_events", 32'(ev_seen), 32'd1);
        check_output("wrap_position", 32'(position), 32'hFFFF);
        check_output("wrap_led", 32'(led), 32'h80);

        // Walk to 00 (no x1 steps), then force a double-bit jump to 11
        clear_tallies();
        apply_stimulus(1'b1, 1'b0, 10);
        apply_stimulus(1'b0, 1'b0, 10);
        check_output("walk00_events", 32'(ev_seen), 32'h0);
        clear_tallies();
        apply_stimulus(1'b1, 1'b1, 10);
        check_output("jump_err_pulses", 32'(err_seen), 32'd1);
        check_output("jump_err_cnt", 32'(err_cnt), 32'd1);
        check_output("jump_events", 32'(ev_seen), 32'h0);
        check_output("jump_dir", 32'(rotation_direction), 32'h0);
        check_output("jump_position", 32'(position), 32'hFFFF);

        clear_tallies();
        for (int j = 0; j < 256; j++) begin
            if (j % 2 == 0) apply_stimulus(1'b0, 1'b0, 8);
            else            apply_stimulus(1'b1, 1'b1, 8);
        end
        check_output("errsat_pulses", 32'(err_seen), 32'd256);
        check_output("errsat_cnt", 32'(err_cnt), 32'd255);

        // x4 left detent with pos_clr landing on the final step
        pos_clr = 1'b1;
        run_cycles(1);
        pos_clr = 1'b0;
        check_output("clr2_err_cnt", 32'(err_cnt), 32'd255);
        quad_x4 = 1'b1;
        clear_tallies();
        apply_stimulus(1'b1, 1'b0, 10);
        apply_stimulus(1'b0, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 10);
        check_output("x4_events", 32'(ev_seen), 32'd3);
        check_output("x4_position", 32'(position), 32'd3);
        check_output("x4_led", 32'(led), 32'h08);
        apply_stimulus(1'b1, 1'b1, 6);
        pos_clr = 1'b1;
        run_cycles(1);
        pos_clr = 1'b0;
        check_output("x4clr_event", 32'(rotation_event), 32'h1);
        check_output("x4clr_position", 32'(position), 32'h0);
        check_output("x4clr_led", 32'(led), 32'h01);
        check_output("x4clr_dir", 32'(rotation_direction), 32'h1);

        // Reset mid-transition, then a fresh step from the loaded state
        apply_stimulus(1'b1, 1'b0, 4);
        rst = 1'b1;
        run_cycles(2);
        rst = 1'b0;
        clear_tallies();
        run_cycles(14);
        check_output("rstmid_events", 32'(ev_seen), 32'h0);
        check_output("rstmid_errors", 32'(err_seen), 32'h0);
        check_output("rstmid_err_cnt", 32'(err_cnt), 32'h0);
        clear_tallies();
        apply_stimulus(1'b0, 1'b0, 10);
        check_output("post_rst_events", 32'(ev_seen), 32'd1);
        check_output("post_rst_position", 32'(position), 32'd1);
        check_output("post_rst_led", 32'(led), 32'h02);
        check_output("post_rst_dir", 32'(rotation_direction), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
